// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline encodings, vectors and IF/ID bubble value
package mips_pkg;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic [1:0] PCSRC_JR   = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_INTR_PC  = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_EXCP_PC  = 32'h8000_0008;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4, input logic [31:0] instr);
        return {pcPlus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] nextInstr,
    input  logic [31:0] nextPcPlus4,
    output logic [31:0] regInstr,
    output logic [31:0] regPcPlus4,
    output logic        regValid
);

    // flush beats hold so a trap can squash ID even while a stall is pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regInstr   <= NOP_INSTR;
            regPcPlus4 <= 32'h0;
            regValid   <= 1'b0;
        end else if (flush) begin
            regInstr   <= NOP_INSTR;
            regPcPlus4 <= 32'h0;
            regValid   <= 1'b0;
        end else if (!hold) begin
            regInstr   <= nextInstr;
            regPcPlus4 <= nextPcPlus4;
            regValid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, next-PC priority mux, IF/ID register
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] INTR_PC  = DEFAULT_INTR_PC,
    parameter logic [31:0] EXCP_PC  = DEFAULT_EXCP_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        ctrl_flush,
    input  logic        bad_op,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic        irq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        pc31,
    output logic        id_flush,
    output logic        epc_we,
    output logic [31:0] epc_value
);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;
    logic        trapTake;
    logic        intrTake;
    logic        redirect;
    logic        fetchHold;
    logic        fetchFlush;

    assign pcPlus4   = pc + 32'd4;
    assign imem_addr = pc;
    assign pc31      = if_id_pc_plus4[31];

    // irq waits out any redirect so EPC never lands on a squashed path
    always_comb begin
        trapTake = bad_op && if_id_valid;
        redirect = branch_taken || (pc_src == PCSRC_JUMP) || (pc_src == PCSRC_JR);
        intrTake = irq && !pc31 && if_id_valid && !stall && !redirect && !trapTake;
    end

    always_comb begin
        nextPc     = pcPlus4;
        fetchHold  = 1'b0;
        fetchFlush = 1'b0;
        if (trapTake) begin
            nextPc     = EXCP_PC;
            fetchFlush = 1'b1;
        end else if (stall) begin
            nextPc    = pc;
            fetchHold = 1'b1;
        end else if (branch_taken) begin
            nextPc     = branch_target;
            fetchFlush = 1'b1;
        end else if (pc_src == PCSRC_JUMP) begin
            nextPc     = jumpTarget(if_id_pc_plus4, if_id_instr);
            fetchFlush = ctrl_flush;
        end else if (pc_src == PCSRC_JR) begin
            nextPc     = {jr_target[31:2], 2'b00};
            fetchFlush = ctrl_flush;
        end else if (intrTake) begin
            nextPc     = INTR_PC;
            fetchFlush = 1'b1;
        end
    end

    always_comb begin
        id_flush  = 1'b0;
        epc_we    = 1'b0;
        epc_value = 32'h0;
        if (rst_n) begin
            id_flush = trapTake || intrTake;
            epc_we   = trapTake || intrTake;
            if (trapTake) begin
                epc_value = if_id_pc_plus4;
            end else if (intrTake) begin
                epc_value = if_id_pc_plus4 - 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= nextPc;
        end
    end

    if_id_reg ifIdReg (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (fetchHold),
        .flush       (fetchFlush),
        .nextInstr   (imem_rdata),
        .nextPcPlus4 (pcPlus4),
        .regInstr    (if_id_instr),
        .regPcPlus4  (if_id_pc_plus4),
        .regValid    (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic        ctrl_flush;
    logic        bad_op;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        pc31;
    logic        id_flush;
    logic        epc_we;
    logic [31:0] epc_value;

    logic        useOvr;
    logic [31:0] ovrVal;

    always #5 clk = ~clk;

    assign imem_rdata = useOvr ? ovrVal : imem_addr;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_src         (pc_src),
        .ctrl_flush     (ctrl_flush),
        .bad_op         (bad_op),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jr_target      (jr_target),
        .irq            (irq),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .pc31           (pc31),
        .id_flush       (id_flush),
        .epc_we         (epc_we),
        .epc_value      (epc_value)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
    } expT;

    expT expQ[$];
    int  nCompared = 0;
    int  nMismatched = 0;

    logic [31:0] mPc = 32'h0;
    logic [31:0] mInstr = 32'h0;
    logic [31:0] mPp4 = 32'h0;
    logic        mValid = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearDrive();
        stall         = 1'b0;
        pc_src        = 2'b00;
        ctrl_flush    = 1'b0;
        bad_op        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jr_target     = 32'h0;
        irq           = 1'b0;
        useOvr        = 1'b0;
        ovrVal        = 32'h0;
    endtask

    // Inputs are already driven; model the cycle, check combinational outputs, then the edge.
    task automatic step(input string tag);
        expT         e;
        expT         got;
        logic [31:0] fetch;
        logic        eFlush;
        logic [31:0] eEpc;
        #1;
        fetch  = useOvr ? ovrVal : mPc;
        e      = '{mPc, mInstr, mPp4, mValid};
        eFlush = 1'b0;
        eEpc   = 32'h0;
        if (!rst_n) begin
            e = '{32'h8000_0000, 32'h0, 32'h0, 1'b0};
        end else if (bad_op && mValid) begin
            e      = '{32'h8000_0008, 32'h0, 32'h0, 1'b0};
            eFlush = 1'b1;
            eEpc   = mPp4;
        end else if (stall) begin
            e = '{mPc, mInstr, mPp4, mValid};
        end else if (branch_taken) begin
            e = '{branch_target, 32'h0, 32'h0, 1'b0};
        end else if (pc_src == 2'b01 || pc_src == 2'b10) begin
            if (ctrl_flush) e = '{32'h0, 32'h0, 32'h0, 1'b0};
            else            e = '{32'h0, fetch, mPc + 32'd4, 1'b1};
            if (pc_src == 2'b01) e.pc = {mPp4[31:28], mInstr[25:0], 2'b00};
            else                 e.pc = {jr_target[31:2], 2'b00};
        end else if (irq && !mPp4[31] && mValid) begin
            e      = '{32'h8000_0004, 32'h0, 32'h0, 1'b0};
            eFlush = 1'b1;
            eEpc   = mPp4 - 32'd4;
        end else begin
            e = '{mPc + 32'd4, fetch, mPc + 32'd4, 1'b1};
        end
        checkVal({tag, "/id_flush"}, {31'b0, id_flush}, {31'b0, eFlush});
        checkVal({tag, "/epc_we"}, {31'b0, epc_we}, {31'b0, eFlush});
        if (eFlush) checkVal({tag, "/epc_value"}, epc_value, eEpc);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        checkVal({tag, "/pc"}, imem_addr, got.pc);
        checkVal({tag, "/instr"}, if_id_instr, got.instr);
        checkVal({tag, "/pc_plus4"}, if_id_pc_plus4, got.pp4);
        checkVal({tag, "/valid"}, {31'b0, if_id_valid}, {31'b0, got.valid});
        checkVal({tag, "/pc31"}, {31'b0, pc31}, {31'b0, got.pp4[31]});
        mPc    = got.pc;
        mInstr = got.instr;
        mPp4   = got.pp4;
        mValid = got.valid;
        @(negedge clk);
    endtask

    initial begin
        clearDrive();
        rst_n = 1'b0;
        step("rst0");
        step("rst1");
        rst_n = 1'b1;
        repeat (3) step("seq");

        branch_taken = 1'b1; branch_target = 32'h0040_0004;
        step("br");
        clearDrive();
        useOvr = 1'b1; ovrVal = 32'h0800_0010;
        step("fetchJ");
        clearDrive();
        pc_src = 2'b01; ctrl_flush = 1'b1;
        step("jump");
        clearDrive();
        pc_src = 2'b10; ctrl_flush = 1'b1; jr_target = 32'h0040_0013;
        step("jr");
        clearDrive();
        step("seq2");

        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_000C;
        step("stallBr");
        stall = 1'b0;
        step("brAfterStall");
        clearDrive();
        step("seq3");

        bad_op = 1'b1;
        step("trap");
        step("trapBubble");
        clearDrive();

        branch_taken = 1'b1; branch_target = 32'h0040_001C;
        step("br2");
        clearDrive();
        step("seq4");
        irq = 1'b1;
        step("irq");
        step("irqBubble");
        step("irqKernel");
        clearDrive();

        branch_taken = 1'b1; branch_target = 32'h0040_0100;
        step("br3");
        clearDrive();
        step("seq5");
        irq = 1'b1; pc_src = 2'b10; jr_target = 32'h0040_0300; ctrl_flush = 1'b0;
        step("irqDefer");
        pc_src = 2'b00;
        step("irqLate");
        clearDrive();

        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step("brWrap");
        clearDrive();
        step("wrap");

        pc_src = 2'b01; bad_op = 1'b1; rst_n = 1'b0;
        step("rstJump");
        rst_n = 1'b1;
        clearDrive();
        step("postRst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Directly upstream of the ID-stage control decoder.
- Owns the PC and selects the next PC: sequential, jump, jump-register, taken branch, exception vector or interrupt vector.
- Fetches from instruction memory and registers instruction, PC+4 and valid into IF/ID.
- Supplies the decoder's kernel-mode bit (pc31). Consumes the decoder's pc_src, ctrl_flush and bad_op.

Parameters:
- RESET_PC, 32'h80000000, PC loaded on reset (kernel space).
- INTR_PC, 32'h80000004, interrupt vector.
- EXCP_PC, 32'h80000008, illegal-instruction vector.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- stall  in  1  load-use hazard from hazard unit; hold PC and IF/ID.
- pc_src  in  2  from decoder: 00 seq, 01 jump (j/jal), 10 jump-register (jr/jalr).
- ctrl_flush  in  1  from decoder; bubble IF/ID on jump.
- bad_op  in  1  from decoder; illegal opcode in ID.
- branch_taken  in  1  ID-stage branch comparator result (already gated by decoder Branch).
- branch_target  in  32  if_id_pc_plus4 + (sext imm << 2), computed in ID.
- jr_target  in  32  forwarded rs value for jr/jalr.
- irq  in  1  level-sensitive external interrupt request.
- imem_addr  out  32  current PC; combinational-read instruction memory.
- imem_rdata  in  32  instruction at imem_addr, same cycle.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered PC+4.
- if_id_valid  out  1  0 = bubble.
- pc31  out  1  if_id_pc_plus4[31]; kernel-mode flag to decoder.
- id_flush  out  1  combinational; ID/EX must load a bubble this cycle.
- epc_we  out  1  combinational; write EPC ($k0 path) this cycle.
- epc_value  out  32  value to write.

Behaviour:
- Reset (rst_n=0 at edge): PC=RESET_PC; if_id_instr=0; if_id_pc_plus4=0; if_id_valid=0. While rst_n=0, id_flush=0 and epc_we=0 (all combinational outputs forced 0).
- Bubble is instr 32'h0 (sll $0,$0,0) with valid=0.
- pc_plus4 = PC+4, mod 2^32 (0xFFFFFFFC wraps to 0).
- Priority each cycle, highest first:
  - bad_op && if_id_valid: PC=EXCP_PC; IF/ID=bubble; id_flush=1; epc_we=1; epc_value=if_id_pc_plus4.
  - stall: PC and IF/ID hold. Redirects and irq are ignored this cycle and re-evaluated next cycle.
  - branch_taken: PC=branch_target; IF/ID=bubble.
  - pc_src==01: PC={if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}; IF/ID=bubble when ctrl_flush.
  - pc_src==10: PC={jr_target[31:2], 2'b00}, low bits forced 0; IF/ID=bubble when ctrl_flush.
  - irq && !pc31 && if_id_valid: PC=INTR_PC; IF/ID=bubble; id_flush=1; epc_we=1; epc_value=if_id_pc_plus4-4, so the ID instruction re-executes.
  - else: PC=pc_plus4; IF/ID={imem_rdata, pc_plus4, 1}.
- irq is masked in kernel mode (pc31=1). It is deferred while a branch or jump redirect is active, so EPC never points at a delay-slot-less squashed path.
- bad_op with if_id_valid=0 is ignored, so a bubble never traps.
- Latency: a redirect decided in ID loads PC at the next edge. Exactly one bubble follows a taken branch or jump; no delay slot.
- Reset mid-stall or mid-redirect: reset wins unconditionally.

Decomposition:
- Shared package mips_pkg: PCSRC_SEQ/PCSRC_JUMP/PCSRC_JR encodings, RESET_PC/INTR_PC/EXCP_PC defaults, NOP_INSTR.
- One sub-module, if_id_reg: instr/pc_plus4/valid register with hold (stall) and bubble (flush) controls, sync active-low reset.
- Next-PC priority mux stays in if_fetch_stage.

Test Plan:
- Reset release, no redirects, imem returns addr: first edge gives if_id_pc_plus4=0x80000004, if_id_instr=0x80000000, valid=1; PC steps by 4.
- if_id_instr=0x08000010 with pc_src=01, ctrl_flush=1, if_id_pc_plus4=0x00400008: next PC=0x00000040, IF/ID bubble; jr_target=0x00400013 with pc_src=10 gives PC=0x00400010.
- stall=1 together with branch_taken=1 for one cycle: PC and IF/ID unchanged. Next cycle with stall=0: PC=branch_target and one bubble.
- bad_op=1, valid=1, if_id_pc_plus4=0x00400010: PC=0x80000008, id_flush=1, epc_we=1, epc_value=0x00400010. With valid=0: no trap.
- irq=1, pc31=0, no redirect, if_id_pc_plus4=0x00400020: PC=0x80000004, epc_value=0x0040001C. Repeat with pc31=1: no interrupt. With a redirect active: interrupt deferred one cycle.
- PC=0xFFFFFFFC sequential: next PC=0x00000000; rst_n=0 during a jump: PC=0x80000000, valid=0.
